// File: rtl/ifu_fetch_master_pkg.sv
// ifu_fetch_master_pkg: shared FSM states, AXI response codes and the default boot PC
package ifu_fetch_master_pkg;
  typedef enum logic [1:0] {REQ, RESP, OUT, WAIT} state_e;
  localparam logic RESP_OKAY = 1'b0;
  localparam logic RESP_ERR = 1'b1;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
endpackage

// File: rtl/ifu_fetch_master.sv
// ifu_fetch_master: single-outstanding instruction fetch over an AXI-lite read channel
module ifu_fetch_master
  import ifu_fetch_master_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic [31:0]      araddr,
  output logic             arvalid,
  input  logic             arready,
  input  logic [31:0]      rdata,
  input  logic             rresp,
  input  logic             rvalid,
  output logic             rready,
  output logic [31:0]      inst,
  output logic [31:0]      inst_pc,
  output logic             inst_err,
  output logic             inst_valid,
  input  logic             inst_ready,
  input  logic             next_pc_valid,
  input  logic [31:0]      next_pc,
  output logic [CNT_W-1:0] fetch_cnt
);
  state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, inst_q, inst_d;
  logic err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    inst_d = inst_q;
    err_d = err_q;
    cnt_d = cnt_q;
    case (state_q)
      REQ: if (arready) state_d = RESP;
      RESP: if (rvalid) begin
        inst_d = rdata;
        err_d = rresp;
        state_d = OUT;
      end
      OUT: if (inst_ready) begin
        cnt_d = cnt_q + CNT_W'(1);
        state_d = WAIT;
      end
      WAIT: if (next_pc_valid) begin
        pc_d = next_pc;
        // a misaligned target is reported to decode as a faulting instruction without touching the bus
        if (next_pc[1:0] == 2'b00) state_d = REQ;
        else begin
          inst_d = '0;
          err_d = RESP_ERR;
          state_d = OUT;
        end
      end
      default: state_d = REQ;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= REQ;
      pc_q <= RESET_PC;
      inst_q <= '0;
      err_q <= RESP_OKAY;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      inst_q <= inst_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end
  assign arvalid = rst && state_q == REQ;
  assign rready = rst && state_q == RESP;
  assign inst_valid = rst && state_q == OUT;
  assign araddr = pc_q;
  assign inst_pc = pc_q;
  assign inst = inst_q;
  assign inst_err = err_q;
  assign fetch_cnt = cnt_q;
endmodule

// File: tb/tb_ifu_fetch_master.sv
// tb_ifu_fetch_master: randomized IFU/decode/write-back environment with a queue-based scoreboard
module tb_ifu_fetch_master;
  localparam int CW = 4;
  localparam logic [31:0] RPC = 32'h8000_0000;
  logic clk = 1'b0, rst = 1'b0;
  logic [31:0] araddr, rdata, inst, inst_pc, next_pc;
  logic arvalid, arready, rresp, rvalid, rready, inst_err, inst_valid, inst_ready, next_pc_valid;
  logic [CW-1:0] fetch_cnt;
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic err;
    int cnt;
  } exp_t;
  logic [31:0] ar_q[$];
  exp_t out_q[$];
  int tests = 0, fails = 0;
  logic [31:0] pc_m;
  int cnt_m;
  ifu_fetch_master #(.RESET_PC(RPC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .inst(inst), .inst_pc(inst_pc), .inst_err(inst_err), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .next_pc_valid(next_pc_valid), .next_pc(next_pc),
    .fetch_cnt(fetch_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_for(input int which);
    int n = 0;
    while (!(which == 0 ? arvalid : inst_valid) && n < 50) begin
      cyc();
      n++;
    end
    if (n >= 50) begin
      tests++;
      fails++;
      $display("FAIL timeout waiting for %s", which == 0 ? "arvalid" : "inst_valid");
    end
  endtask
  logic [31:0] last_inst;
  logic last_err, last_v = 1'b0;
  exp_t e;
  always @(negedge clk) begin
    if (rst) begin
      if (arvalid) begin
        tests++;
        if (ar_q.size() == 0) begin
          fails++;
          $display("FAIL spurious_arvalid: got arvalid=1 expected 0 addr %h", araddr);
        end else if (arready) chk("araddr", araddr, ar_q.pop_front());
      end
      if (inst_valid && last_v) begin
        chk("inst_hold", inst, last_inst);
        chk("err_hold", 32'(inst_err), 32'(last_err));
      end
      if (inst_valid && inst_ready) begin
        tests++;
        if (out_q.size() == 0) begin
          fails++;
          $display("FAIL spurious_inst: got inst %h pc %h expected none", inst, inst_pc);
        end else begin
          e = out_q.pop_front();
          chk("inst", inst, e.inst);
          chk("inst_pc", inst_pc, e.pc);
          chk("inst_err", 32'(inst_err), 32'(e.err));
          chk("cnt_at_accept", 32'(fetch_cnt), 32'(e.cnt));
        end
      end
      last_v <= inst_valid && !inst_ready;
      last_inst <= inst;
      last_err <= inst_err;
    end else last_v <= 1'b0;
  end
  task automatic run(input int n);
    logic [31:0] d, npc;
    logic r;
    bit need_ar = 1'b1;
    pc_m = RPC;
    cnt_m = 0;
    for (int i = 0; i < n; i++) begin
      if (need_ar) begin
        ar_q.push_back(pc_m);
        wait_for(0);
        repeat ($urandom_range(1, 4)) begin
          chk("arvalid_hold", 32'(arvalid), 1);
          chk("araddr_hold", araddr, pc_m);
          rvalid = 1'($urandom_range(0, 1));
          rdata = $urandom;
          rresp = 1'($urandom_range(0, 1));
          cyc();
        end
        arready = 1'b1;
        rvalid = 1'($urandom_range(0, 1));
        rdata = 32'hBAD0_0000 | i;
        cyc();
        arready = 1'b0;
        rvalid = 1'b0;
        d = i == 0 ? 32'h0000_0413 : i == 1 ? 32'hDEAD_BEEF : $urandom;
        r = i == 0 ? 1'b0 : i == 1 ? 1'b1 : 1'($urandom_range(0, 3) == 0);
        out_q.push_back('{d, pc_m, r, cnt_m});
        repeat ($urandom_range(0, 3)) cyc();
        chk("rready", 32'(rready), 1);
        rvalid = 1'b1;
        rdata = d;
        rresp = r;
        cyc();
        rvalid = 1'b0;
      end else out_q.push_back('{32'h0, pc_m, 1'b1, cnt_m});
      wait_for(1);
      repeat ($urandom_range(0, 4)) begin
        next_pc_valid = 1'($urandom_range(0, 1));
        next_pc = $urandom;
        cyc();
      end
      next_pc_valid = 1'b0;
      inst_ready = 1'b1;
      cyc();
      inst_ready = 1'b0;
      cnt_m = (cnt_m + 1) % (1 << CW);
      chk("fetch_cnt", 32'(fetch_cnt), 32'(cnt_m));
      if (i < n - 1) begin
        repeat ($urandom_range(0, 2)) cyc();
        npc = $urandom;
        if ($urandom_range(0, 3) != 0) npc[1:0] = 2'b00;
        if (i == 0) npc = 32'h8000_0004;
        if (i == 1) npc = 32'h8000_0006;
        next_pc_valid = 1'b1;
        next_pc = npc;
        cyc();
        next_pc_valid = 1'b0;
        pc_m = npc;
        need_ar = npc[1:0] == 2'b00;
      end
    end
  endtask
  initial begin
    {arready, rvalid, rresp, inst_ready, next_pc_valid} = '0;
    rdata = '0;
    next_pc = '0;
    repeat (2) cyc();
    chk("rst_arvalid", 32'(arvalid), 0);
    chk("rst_rready", 32'(rready), 0);
    chk("rst_inst_valid", 32'(inst_valid), 0);
    chk("rst_fetch_cnt", 32'(fetch_cnt), 0);
    chk("rst_inst", inst, 0);
    chk("rst_inst_err", 32'(inst_err), 0);
    chk("rst_araddr", araddr, RPC);
    rst = 1'b1;
    run(40);
    ar_q.push_back(32'h8000_0010);
    next_pc_valid = 1'b1;
    next_pc = 32'h8000_0010;
    cyc();
    next_pc_valid = 1'b0;
    wait_for(0);
    arready = 1'b1;
    cyc();
    arready = 1'b0;
    chk("rready_before_reset", 32'(rready), 1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_arvalid", 32'(arvalid), 0);
    chk("midrst_rready", 32'(rready), 0);
    chk("midrst_inst_valid", 32'(inst_valid), 0);
    chk("midrst_fetch_cnt", 32'(fetch_cnt), 0);
    chk("midrst_araddr", araddr, RPC);
    cyc();
    rst = 1'b1;
    run(6);
    chk("ar_q_drained", 32'(ar_q.size()), 0);
    chk("out_q_drained", 32'(out_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
